// File: rtl/branch_cond_unit.sv
// branch_cond_unit
// Holds the architectural NZCV register and resolves B.cond / CBZ / CBNZ in ID.
// A flag setter sitting in EX is handled by a combinational bypass (BYPASS=1)
// or by holding ID for one cycle (BYPASS=0). The unit also keeps saturating
// counters of taken and not-taken branches.
module branch_cond_unit #(
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_set_flags,
    input  logic             ex_negative,
    input  logic             ex_zero,
    input  logic             ex_carry_out,
    input  logic             ex_overflow,
    input  logic             id_valid,
    input  logic             id_is_bcond,
    input  logic             id_is_cbz,
    input  logic             id_is_cbnz,
    input  logic [3:0]       id_cond,
    input  logic [63:0]      id_rt_value,
    input  logic             cnt_clear,
    output logic [3:0]       flags_q,
    output logic             branch_taken,
    output logic             stall,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt
);

    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_STALL = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       ex_writes_flags;
    logic       hazard;
    logic [3:0] ex_flags;
    logic [3:0] eval_flags;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       cond_true;
    logic       rt_is_zero;
    logic       is_branch;
    logic       branch_ok;
    logic       resolve;

    assign ex_writes_flags = ex_valid & ex_set_flags;
    assign ex_flags        = {ex_negative, ex_zero, ex_carry_out, ex_overflow};
    assign hazard          = id_valid & id_is_bcond & ex_writes_flags;

    // The stall variant only ever holds ID in IDLE; the STALL cycle resolves.
    assign stall = (BYPASS == 1'b0) & (state_q == ST_IDLE) & hazard;

    // With bypass the B.cond sees the flags EX is producing right now.
    assign eval_flags = ((BYPASS == 1'b1) && hazard) ? ex_flags : flags_q;
    assign flag_n     = eval_flags[3];
    assign flag_z     = eval_flags[2];
    assign flag_c     = eval_flags[1];
    assign flag_v     = eval_flags[0];

    // Decode the B.cond condition field against the selected flag set.
    always_comb begin
        cond_true = 1'b1;
        case (id_cond)
            4'h0:    cond_true = flag_z;
            4'h1:    cond_true = !flag_z;
            4'h2:    cond_true = flag_c;
            4'h3:    cond_true = !flag_c;
            4'h4:    cond_true = flag_n;
            4'h5:    cond_true = !flag_n;
            4'h6:    cond_true = flag_v;
            4'h7:    cond_true = !flag_v;
            4'h8:    cond_true = flag_c & !flag_z;
            4'h9:    cond_true = !(flag_c & !flag_z);
            4'hA:    cond_true = (flag_n == flag_v);
            4'hB:    cond_true = (flag_n != flag_v);
            4'hC:    cond_true = !flag_z & (flag_n == flag_v);
            4'hD:    cond_true = !(!flag_z & (flag_n == flag_v));
            default: cond_true = 1'b1;
        endcase
    end

    assign rt_is_zero = (id_rt_value == 64'd0);
    assign is_branch  = id_is_bcond | id_is_cbz | id_is_cbnz;

    // Pick the outcome of the highest-priority branch type present in ID.
    always_comb begin
        branch_ok = 1'b0;
        if (id_is_bcond) begin
            branch_ok = cond_true;
        end else if (id_is_cbz) begin
            branch_ok = rt_is_zero;
        end else if (id_is_cbnz) begin
            branch_ok = !rt_is_zero;
        end
    end

    assign resolve      = id_valid & is_branch & !stall;
    assign branch_taken = resolve & branch_ok;

    // Next state: a stall cycle is always followed by exactly one resolve cycle.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = stall ? ST_STALL : ST_IDLE;
            ST_STALL: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register for the stall sequencer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Architectural NZCV, loaded by any valid flag setter regardless of stall.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else if (ex_writes_flags) begin
            flags_q <= ex_flags;
        end
    end

    // Saturating branch outcome counters; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (cnt_clear) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (resolve) begin
            if (branch_ok) begin
                if (taken_cnt != CNT_MAX) begin
                    taken_cnt <= taken_cnt + CNT_ONE;
                end
            end else begin
                if (not_taken_cnt != CNT_MAX) begin
                    not_taken_cnt <= not_taken_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: three instances (stall variant, bypass variant,
// bypass with 4-bit counters) share one input stream. A behavioural model
// predicts every output each cycle; directed literals pin the model.
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_set_flags = 1'b0;
    logic        ex_negative = 1'b0;
    logic        ex_zero = 1'b0;
    logic        ex_carry_out = 1'b0;
    logic        ex_overflow = 1'b0;
    logic        id_valid = 1'b0;
    logic        id_is_bcond = 1'b0;
    logic        id_is_cbz = 1'b0;
    logic        id_is_cbnz = 1'b0;
    logic [3:0]  id_cond = 4'h0;
    logic [63:0] id_rt_value = 64'd0;
    logic        cnt_clear = 1'b0;

    logic [3:0]  u0_flags, u1_flags, u2_flags;
    logic        u0_bt, u1_bt, u2_bt;
    logic        u0_stall, u1_stall, u2_stall;
    logic [31:0] u0_tk, u0_nt, u1_tk, u1_nt;
    logic [3:0]  u2_tk, u2_nt;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, one slot per instance
    bit          m_byp [3] = '{1'b0, 1'b1, 1'b1};
    longint      m_max [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
    bit   [3:0]  m_flags [3];
    bit          m_pend [3];
    longint      m_tk [3];
    longint      m_nt [3];

    initial forever #5 clk = ~clk;

    branch_cond_unit #(.BYPASS(1'b0), .CNT_W(32)) u0 (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
        .ex_negative(ex_negative), .ex_zero(ex_zero), .ex_carry_out(ex_carry_out),
        .ex_overflow(ex_overflow), .id_valid(id_valid), .id_is_bcond(id_is_bcond),
        .id_is_cbz(id_is_cbz), .id_is_cbnz(id_is_cbnz), .id_cond(id_cond),
        .id_rt_value(id_rt_value), .cnt_clear(cnt_clear), .flags_q(u0_flags),
        .branch_taken(u0_bt), .stall(u0_stall), .taken_cnt(u0_tk), .not_taken_cnt(u0_nt));

    branch_cond_unit #(.BYPASS(1'b1), .CNT_W(32)) u1 (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
        .ex_negative(ex_negative), .ex_zero(ex_zero), .ex_carry_out(ex_carry_out),
        .ex_overflow(ex_overflow), .id_valid(id_valid), .id_is_bcond(id_is_bcond),
        .id_is_cbz(id_is_cbz), .id_is_cbnz(id_is_cbnz), .id_cond(id_cond),
        .id_rt_value(id_rt_value), .cnt_clear(cnt_clear), .flags_q(u1_flags),
        .branch_taken(u1_bt), .stall(u1_stall), .taken_cnt(u1_tk), .not_taken_cnt(u1_nt));

    branch_cond_unit #(.BYPASS(1'b1), .CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
        .ex_negative(ex_negative), .ex_zero(ex_zero), .ex_carry_out(ex_carry_out),
        .ex_overflow(ex_overflow), .id_valid(id_valid), .id_is_bcond(id_is_bcond),
        .id_is_cbz(id_is_cbz), .id_is_cbnz(id_is_cbnz), .id_cond(id_cond),
        .id_rt_value(id_rt_value), .cnt_clear(cnt_clear), .flags_q(u2_flags),
        .branch_taken(u2_bt), .stall(u2_stall), .taken_cnt(u2_tk), .not_taken_cnt(u2_nt));

    // ARM-style evaluation: even codes test a base predicate, odd codes invert it.
    function automatic bit cond_holds(input bit [3:0] cond, input bit [3:0] f);
        bit n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cond[3:1] == 3'd7) return 1'b1;
        return base ^ cond[0];
    endfunction

    // Expected combinational outputs of instance i for the current inputs.
    function automatic void expect_out(input int i, output bit e_stall,
                                       output bit e_bt, output bit e_res);
        bit       hz;
        bit       ok;
        bit [3:0] f;
        hz = id_valid && id_is_bcond && ex_valid && ex_set_flags;
        f = m_flags[i];
        e_stall = 1'b0;
        if (m_byp[i]) begin
            if (hz) f = {ex_negative, ex_zero, ex_carry_out, ex_overflow};
        end else if (!m_pend[i] && hz) begin
            e_stall = 1'b1;
        end
        if (id_is_bcond)     ok = cond_holds(id_cond, f);
        else if (id_is_cbz)  ok = (id_rt_value == 64'd0);
        else                 ok = (id_rt_value != 64'd0);
        e_res = id_valid && (id_is_bcond || id_is_cbz || id_is_cbnz) && !e_stall;
        e_bt  = e_res && ok;
    endfunction

    // Advance the model on each clock edge, clear it on reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                m_flags[i] <= 4'b0000;
                m_pend[i]  <= 1'b0;
                m_tk[i]    <= 0;
                m_nt[i]    <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                bit s, t, r;
                expect_out(i, s, t, r);
                if (cnt_clear) begin
                    m_tk[i] <= 0;
                    m_nt[i] <= 0;
                end else if (r) begin
                    if (t) begin
                        if (m_tk[i] < m_max[i]) m_tk[i] <= m_tk[i] + 1;
                    end else begin
                        if (m_nt[i] < m_max[i]) m_nt[i] <= m_nt[i] + 1;
                    end
                end
                if (ex_valid && ex_set_flags)
                    m_flags[i] <= {ex_negative, ex_zero, ex_carry_out, ex_overflow};
                m_pend[i] <= !m_byp[i] && s;
            end
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic compare_one(input int i, input logic [3:0] f, input logic bt,
                               input logic st, input longint tk, input longint nt);
        bit s, t, r;
        expect_out(i, s, t, r);
        checkOutput($sformatf("u%0d.flags_q", i), f, m_flags[i]);
        checkOutput($sformatf("u%0d.branch_taken", i), bt, t);
        checkOutput($sformatf("u%0d.stall", i), st, s);
        checkOutput($sformatf("u%0d.taken_cnt", i), tk, m_tk[i]);
        checkOutput($sformatf("u%0d.not_taken_cnt", i), nt, m_nt[i]);
    endtask

    // Compare every instance against the model away from the active edge.
    always @(negedge clk) begin
        compare_one(0, u0_flags, u0_bt, u0_stall, u0_tk, u0_nt);
        compare_one(1, u1_flags, u1_bt, u1_stall, u1_tk, u1_nt);
        compare_one(2, u2_flags, u2_bt, u2_stall, u2_tk, u2_nt);
    end

    // Drive one cycle of pipeline inputs after the edge, return at the next negedge.
    task automatic applyStimulus(input bit ev, input bit esf, input bit [3:0] nzcv,
                                 input bit iv, input bit bc, input bit cz, input bit cnz,
                                 input bit [3:0] cond, input bit [63:0] rt, input bit clr);
        @(posedge clk);
        #1;
        ex_valid = ev; ex_set_flags = esf;
        {ex_negative, ex_zero, ex_carry_out, ex_overflow} = nzcv;
        id_valid = iv; id_is_bcond = bc; id_is_cbz = cz; id_is_cbnz = cnz;
        id_cond = cond; id_rt_value = rt; cnt_clear = clr;
        @(negedge clk);
    endtask

    initial begin
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // B.EQ with no setter, flags zero after reset
        applyStimulus(0, 0, 4'b0000, 1, 1, 0, 0, 4'h0, 64'd0, 0);
        checkOutput("lit.reset_flags", u0_flags, 0);
        checkOutput("lit.beq_untaken", u1_bt, 0);
        checkOutput("lit.reset_stall", u0_stall, 0);

        // SUBS (Z=1,C=1) in EX with B.EQ in ID
        applyStimulus(1, 1, 4'b0110, 1, 1, 0, 0, 4'h0, 64'd0, 0);
        checkOutput("lit.nt_cnt_after_first", u0_nt, 1);
        checkOutput("lit.byp_taken_same_cycle", u1_bt, 1);
        checkOutput("lit.byp_no_stall", u1_stall, 0);
        checkOutput("lit.stl_stall_cycle0", u0_stall, 1);
        checkOutput("lit.stl_untaken_cycle0", u0_bt, 0);

        // ID held, EX bubble
        applyStimulus(0, 0, 4'b0000, 1, 1, 0, 0, 4'h0, 64'd0, 0);
        checkOutput("lit.byp_flags_loaded", u1_flags, 4'b0110);
        checkOutput("lit.byp_taken_cnt", u1_tk, 1);
        checkOutput("lit.stl_stall_cycle1", u0_stall, 0);
        checkOutput("lit.stl_taken_cycle1", u0_bt, 1);
        checkOutput("lit.stl_flags_cycle1", u0_flags, 4'b0110);
        checkOutput("lit.stl_cnt_cycle1", u0_tk, 0);

        applyStimulus(0, 0, 4'b0000, 0, 0, 0, 0, 4'h0, 64'd0, 0);
        checkOutput("lit.stl_cnt_cycle2", u0_tk, 1);
        checkOutput("lit.byp_cnt_cycle2", u1_tk, 2);

        // Setter N=1,V=1 while ID holds no valid instruction
        applyStimulus(1, 1, 4'b1001, 0, 1, 0, 0, 4'hE, 64'd0, 0);
        checkOutput("lit.invalid_id_untaken", u1_bt, 0);
        checkOutput("lit.invalid_id_nostall", u0_stall, 0);

        applyStimulus(0, 0, 4'b0000, 1, 1, 0, 0, 4'hA, 64'd0, 0);
        checkOutput("lit.flags_1001", u1_flags, 4'b1001);
        checkOutput("lit.cond_ge", u1_bt, 1);
        applyStimulus(0, 0, 4'b0000, 1, 1, 0, 0, 4'hB, 64'd0, 0);
        checkOutput("lit.cond_lt", u1_bt, 0);
        applyStimulus(0, 0, 4'b0000, 1, 1, 0, 0, 4'hC, 64'd0, 0);
        checkOutput("lit.cond_gt", u1_bt, 1);
        applyStimulus(0, 0, 4'b0000, 1, 1, 0, 0, 4'hD, 64'd0, 0);
        checkOutput("lit.cond_le", u1_bt, 0);
        applyStimulus(0, 0, 4'b0000, 1, 1, 0, 0, 4'hE, 64'd0, 0);
        checkOutput("lit.cond_al", u1_bt, 1);

        // CBZ / CBNZ with a setter in EX never stall
        applyStimulus(1, 1, 4'b0100, 1, 0, 1, 0, 4'h0, 64'd0, 0);
        checkOutput("lit.cbz_taken", u0_bt, 1);
        checkOutput("lit.cbz_nostall", u0_stall, 0);
        applyStimulus(1, 1, 4'b0010, 1, 0, 0, 1, 4'h0, 64'h8000_0000_0000_0000, 0);
        checkOutput("lit.cbnz_taken", u0_bt, 1);
        checkOutput("lit.cbnz_nostall", u0_stall, 0);

        // B.EQ and CBZ both set: B.EQ wins and fails with Z=0
        applyStimulus(0, 0, 4'b0000, 1, 1, 1, 0, 4'h0, 64'd0, 0);
        checkOutput("lit.priority_bcond", u1_bt, 0);

        applyStimulus(0, 0, 4'b0000, 0, 0, 0, 0, 4'h0, 64'd0, 1);
        checkOutput("lit.narrow_taken_before_clear", u2_tk, 7);
        checkOutput("lit.narrow_nt_before_clear", u2_nt, 4);

        // Saturation of the 4-bit counter
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 0, 4'b0000, 1, 1, 0, 0, 4'hE, 64'd0, 0);
        end
        checkOutput("lit.narrow_15", u2_tk, 15);
        checkOutput("lit.wide_15", u1_tk, 15);
        applyStimulus(0, 0, 4'b0000, 1, 1, 0, 0, 4'hE, 64'd0, 1);
        checkOutput("lit.narrow_saturated", u2_tk, 15);
        checkOutput("lit.wide_16", u1_tk, 16);
        applyStimulus(0, 0, 4'b0000, 0, 0, 0, 0, 4'h0, 64'd0, 0);
        checkOutput("lit.narrow_cleared", u2_tk, 0);
        checkOutput("lit.wide_cleared", u1_tk, 0);

        // Reset arriving while the stall variant is in its STALL cycle
        applyStimulus(1, 1, 4'b0100, 1, 1, 0, 0, 4'h0, 64'd0, 0);
        checkOutput("lit.rst_pre_stall", u0_stall, 1);
        @(posedge clk);
        #1 ex_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        checkOutput("lit.rst_stall_drop", u0_stall, 0);
        checkOutput("lit.rst_flags_zero", u0_flags, 0);
        checkOutput("lit.rst_taken_zero", u0_tk, 0);
        checkOutput("lit.rst_nt_zero", u0_nt, 0);
        @(negedge clk);
        reset = 1'b1;

        // B.NE resolves from IDLE with flags zero
        applyStimulus(0, 0, 4'b0000, 1, 1, 0, 0, 4'h1, 64'd0, 0);
        checkOutput("lit.post_rst_taken", u0_bt, 1);
        checkOutput("lit.post_rst_nostall", u0_stall, 0);

        applyStimulus(0, 0, 4'b0000, 0, 0, 0, 0, 4'h0, 64'd0, 0);
        applyStimulus(0, 0, 4'b0000, 0, 0, 0, 0, 4'h0, 64'd0, 0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Consumer side of the ALU status flags in the pipelined LEGv8 CPU. It holds the architectural NZCV register, loads it when a flag-setting instruction (ADDS/SUBS) in EX drives the ALU `negative`/`zero`/`carry_out`/`overflow` outputs, and resolves B.cond, CBZ and CBNZ in ID. An in-flight flag setter is handled either by combinational bypass or by a one-cycle stall, selected by parameter. Saturating taken/not-taken counters are provided for performance measurement.

## Interface
- BYPASS, 1, 1 = ID uses EX flags combinationally; 0 = stall ID one cycle instead
- CNT_W, 32, width of each performance counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- ex_valid  in  1  EX holds a real instruction
- ex_set_flags  in  1  EX instruction writes NZCV
- ex_negative, ex_zero, ex_carry_out, ex_overflow  in  1 each  ALU flag outputs of EX instruction
- id_valid  in  1  ID holds a real instruction
- id_is_bcond, id_is_cbz, id_is_cbnz  in  1 each  ID branch type
- id_cond  in  4  B.cond condition field
- id_rt_value  in  64  forwarded Rt operand for CBZ/CBNZ
- cnt_clear  in  1  synchronous clear of both counters
- flags_q  out  4  architectural {N,Z,C,V}
- branch_taken  out  1  ID branch resolves taken this cycle (also the IF flush request)
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- taken_cnt, not_taken_cnt  out  CNT_W each  resolved-branch counters

## Operation
- Flag load: on edge where ex_valid & ex_set_flags, flags_q <= {ex_negative, ex_zero, ex_carry_out, ex_overflow}; otherwise holds. Independent of stall state.
- Conditions (id_cond, evaluated on flag set F): 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !(C&!Z); A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE !(!Z&(N==V)); E, F always.
- Branch type priority when several asserted: bcond > cbz > cbnz. CBZ taken iff id_rt_value == 0; CBNZ taken iff != 0; neither ever stalls.
- hazard = id_valid & id_is_bcond & ex_valid & ex_set_flags.
- BYPASS=1: F = EX flags when hazard, else flags_q. stall always 0. FSM unused.
- BYPASS=0 FSM, two states:
  - IDLE: if hazard -> stall=1, branch_taken=0, no count, next STALL. Else resolve with F=flags_q.
  - STALL: stall=0; resolve B.cond with F=flags_q (now holding setter's flags); next IDLE unconditionally. A flag setter in EX during STALL updates flags_q at the edge but does not affect this decision.
- Resolution cycle: branch_taken = id_valid & branch & condition; on the edge, taken_cnt++ if taken, not_taken_cnt++ if a valid branch resolved not-taken. No count when id_valid=0, no branch, or stall=1.
- Counters saturate at 2^CNT_W-1. cnt_clear wins over increment in the same cycle.
- branch_taken combinational from current ID inputs and state; stall combinational from state and hazard.

## Timing
- Reset (asynchronous assert, sync-to-clk release by top level): flags_q=0, state IDLE, counters 0; hence stall=0 and B.cond uses flags 0 immediately.
- Flag load latency 1 cycle: flags_q visible the cycle after the EX setter.
- B.cond behind adjacent setter: BYPASS=1 resolves same cycle (0 extra); BYPASS=0 resolves 1 cycle later, stall high exactly one cycle; the ID inputs are held stable by the pipeline across it.
- Setter two or more instructions ahead: no hazard, flags_q already current, no stall.
- Reset mid-STALL: returns to IDLE, stall drops immediately, no count recorded.
- Branch not in ID (id_valid=0): branch_taken=0 regardless of other inputs.

## Test plan
- Reset then B.EQ (cond 0) with no setter -> flags_q=0000, branch_taken=0, not_taken_cnt=1.
- SUBS in EX with zero=1, carry=1, B.EQ in ID, BYPASS=1 -> branch_taken=1 same cycle, stall=0, next cycle flags_q=0110, taken_cnt=1.
- Same stimulus, BYPASS=0 -> cycle0 stall=1, branch_taken=0; cycle1 stall=0, branch_taken=1, flags_q=0110; taken_cnt=1 only after cycle1.
- flags_q=1001 (N=1,V=1): cond A GE -> 1, B LT -> 0, C GT -> 1, D LE -> 0, E -> 1; CBZ rt=0 -> 1, CBNZ rt=0x8000_0000_0000_0000 -> 1, no stall even with EX setter.
- CNT_W=4: 15 taken branches -> taken_cnt=15; 16th -> stays 15; cnt_clear with a taken branch same cycle -> 0.
- BYPASS=0, reset asserted during STALL cycle -> stall=0 and flags_q=0 immediately, counters 0, next B.cond resolves from IDLE.
